// File: rtl/clken_synth.sv
// clken_synth -- multi-channel fractional clock-enable generator.
//
// One phase accumulator (NCO) per channel turns the system clock into a
// stream of single-cycle enable pulses whose mean rate is
// f_refclk * inc / 2^ACC_W. Increments are reprogrammed through a
// valid/ready port. A new value waits in a shadow register until the
// target channel's next wrap, so no partial period is ever produced.
// `locked` reports that every rate has been stable for LOCK_CYCLES cycles.
//
// Build option: define CLKEN_SYNTH_TOGGLE_EN to add the `outclk` port.
// That port carries a ~50% duty square wave per channel that toggles on
// every enable pulse. Without the macro, the port and its flops are absent.
//
// All logic is clocked on the rising edge of refclk. Reset (rst) is
// synchronous and active-high.

module clken_synth #(
  parameter int unsigned     NUM_CH      = 4,             // 1..8 channels
  parameter int unsigned     ACC_W       = 32,            // 8..32 bits
  parameter longint unsigned INC_RST     = 64'd761519005, // reset increment
  parameter int unsigned     LOCK_CYCLES = 1024           // >= 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_chan,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
`ifdef CLKEN_SYNTH_TOGGLE_EN
  output logic [NUM_CH-1:0] outclk,
`endif
  output logic              locked
);

  // ---------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------
  localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_RST);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES);
  localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);

  // The config port is either idle (ready) or holding one pending update.
  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  cfg_state_e        state_q;
  cfg_state_e        state_d;
  logic              pending;

  logic [ACC_W-1:0]  acc_q   [NUM_CH];
  logic [ACC_W-1:0]  inc_q   [NUM_CH];
  logic [ACC_W-1:0]  acc_sum [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] tgt_sel;
  logic [NUM_CH-1:0] apply;
  logic              apply_any;

  logic [ACC_W-1:0]  shadow_inc_q;
  logic [2:0]        shadow_chan_q;

  logic              chan_ok;
  logic              accept;
  logic              accept_ok;
  logic              accept_bad;

  logic [CNT_W-1:0]  settle_q;
  logic              locked_q;
  logic              cfg_err_q;
  logic [NUM_CH-1:0] clken_q;

  // ---------------------------------------------------------------------
  // Config request decode
  // ---------------------------------------------------------------------
  // A transfer happens only while ready. Requests for a channel that does
  // not exist are consumed and flagged, and they change nothing else.
  assign chan_ok    = ({1'b0, cfg_chan} < NUM_CH_L);
  assign accept     = cfg_valid & cfg_ready;
  assign accept_ok  = accept & chan_ok;
  assign accept_bad = accept & ~chan_ok;

  // ---------------------------------------------------------------------
  // Phase accumulators
  // ---------------------------------------------------------------------
  // Per-channel phase add. The extra top bit of the sum is the overflow
  // that becomes the enable pulse.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      {carry[i], acc_sum[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Decide where a pending increment lands. Normally it lands on the
  // target's wrap. A stopped channel never wraps, so it takes the new value
  // straight away. The acceptance cycle can never apply, because pending is
  // still low then.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_sel[i] = (shadow_chan_q == 3'(i));
      apply[i]   = pending & tgt_sel[i] & (carry[i] | (inc_q[i] == '0));
    end
    apply_any = |apply;
  end

  // Accumulators advance every cycle. A pending increment replaces the old
  // one in the same cycle the accumulator wraps, and acc itself is kept.
  // NOTE: state registers use non-blocking (<=) assignments so that every
  // flop samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT;
      end
      clken_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_sum[i];
        if (apply[i]) begin
          inc_q[i] <= shadow_inc_q;
        end
      end
      clken_q <= carry;
    end
  end

  // Capture the requested channel and increment on an accepted request.
  // NOTE: the shadow register holds data only. Its contents are not used
  // while no update is pending, so it has no reset and is loaded only on
  // acceptance. Reset clears the pending flag, which drops any update.
  always_ff @(posedge refclk) begin
    if (accept_ok) begin
      shadow_inc_q  <= cfg_inc;
      shadow_chan_q <= cfg_chan;
    end
  end

  // ---------------------------------------------------------------------
  // Config handshake FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= CFG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: go pending on a valid accept, go idle on apply.
  always_comb begin
    // NOTE: assign a default first, so that every path through the block
    // drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      CFG_IDLE: if (accept_ok) state_d = CFG_PEND;
      CFG_PEND: if (apply_any) state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  // Output decode: ready exactly while no update is pending.
  always_comb begin
    cfg_ready = (state_q == CFG_IDLE);
    pending   = (state_q == CFG_PEND);
  end

  // ---------------------------------------------------------------------
  // Lock tracking and error pulse
  // ---------------------------------------------------------------------
  // The settle counter runs down to zero and restarts on every rate change.
  // locked needs a drained counter and no update in flight.
  always_ff @(posedge refclk) begin
    if (rst) begin
      settle_q <= CNT_INIT;
      locked_q <= 1'b0;
    end else if (apply_any) begin
      settle_q <= CNT_INIT;
      locked_q <= 1'b0;
    end else begin
      if (settle_q != '0) begin
        settle_q <= settle_q - CNT_W'(1);
      end
      locked_q <= (settle_q == '0) & ~pending;
    end
  end

  // A request for a channel that does not exist gives a one-cycle error pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= accept_bad;
    end
  end

  assign clken   = clken_q;
  assign cfg_err = cfg_err_q;
  assign locked  = locked_q;

`ifdef CLKEN_SYNTH_TOGGLE_EN
  // ---------------------------------------------------------------------
  // Optional square-wave outputs
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] outclk_q;

  // Toggle on each enable pulse, so the output runs at half the enable rate.
  // A stopped channel has no pulses and therefore keeps its level.
  always_ff @(posedge refclk) begin
    if (rst) begin
      outclk_q <= '0;
    end else begin
      outclk_q <= outclk_q ^ clken_q;
    end
  end

  assign outclk = outclk_q;
`endif

endmodule

// File: tb/tb_clken_synth.sv
// Self-checking bench for clken_synth.
// The main instance is small (ACC_W=8, inc 64, lock 16), so periods are
// short and easy to reason about. A second 32-bit single-channel instance
// checks the real 50 MHz -> 8.865248 MHz rate. Directed scenarios use
// hand-derived expectations. The randomized scenario compares against a
// cycle model built from the accumulator and handshake rules.

module tb_clken_synth;

  localparam int NCH  = 4;
  localparam int AW   = 8;
  localparam int M    = 256;
  localparam int INC0 = 64;
  localparam int LOCK = 16;
  localparam longint unsigned INC32 = 761519005;
  localparam int LOCK32 = 1024;

  logic           refclk    = 1'b0;
  logic           rst       = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [2:0]     cfg_chan  = 3'd0;
  logic [AW-1:0]  cfg_inc   = '0;
  logic           cfg_ready;
  logic           cfg_err;
  logic           locked;
  logic [NCH-1:0] clken;

  logic           cfg_ready32;
  logic           cfg_err32;
  logic           locked32;
  logic [0:0]     clken32;

`ifdef CLKEN_SYNTH_TOGGLE_EN
  logic [NCH-1:0] outclk;
  logic [0:0]     outclk32;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  int             m_acc [NCH];
  int             m_inc [NCH];
  int             m_chan;
  int             m_shadow;
  int             m_cnt;
  bit             m_pend;
  bit             m_locked;
  bit             m_err;
  bit [NCH-1:0]   m_clken;

  always #5 refclk = ~refclk;

  clken_synth #(
    .NUM_CH(NCH), .ACC_W(AW), .INC_RST(INC0), .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk(refclk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_inc(cfg_inc), .cfg_err(cfg_err),
    .clken(clken),
`ifdef CLKEN_SYNTH_TOGGLE_EN
    .outclk(outclk),
`endif
    .locked(locked)
  );

  clken_synth #(
    .NUM_CH(1), .ACC_W(32), .INC_RST(INC32), .LOCK_CYCLES(LOCK32)
  ) dut32 (
    .refclk(refclk), .rst(rst),
    .cfg_valid(1'b0), .cfg_ready(cfg_ready32),
    .cfg_chan(3'd0), .cfg_inc(32'd0), .cfg_err(cfg_err32),
    .clken(clken32),
`ifdef CLKEN_SYNTH_TOGGLE_EN
    .outclk(outclk32),
`endif
    .locked(locked32)
  );

  // Advance the model by one edge, using the inputs that the DUT will sample.
  task automatic model_step();
    bit [NCH-1:0] ovf;
    bit           applied;
    int           s;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_inc[i] = INC0;
      end
      m_pend = 0; m_cnt = LOCK; m_locked = 0; m_err = 0; m_clken = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s        = m_acc[i] + m_inc[i];
        ovf[i]   = (s >= M);
        m_acc[i] = s % M;
      end
      applied  = m_pend && (ovf[m_chan] || m_inc[m_chan] == 0);
      m_locked = !applied && (m_cnt == 0) && !m_pend;
      if (applied) begin
        m_inc[m_chan] = m_shadow;
        m_cnt  = LOCK;
        m_pend = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
      m_err = 0;
      if (cfg_valid && !m_pend && !applied) begin
        if (int'(cfg_chan) < NCH) begin
          m_pend = 1; m_chan = int'(cfg_chan); m_shadow = int'(cfg_inc);
        end else begin
          m_err = 1;
        end
      end
      m_clken = ovf;
    end
  endtask

  // One clock: the model steps, then outputs are read 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [NCH-1:0] exp;
    rst = 1'b1;
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (clken !== '0) begin bad++; $display("FAIL reset_clken got=%b want=0", clken); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
    end
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (cyc % 4 == 0) ? '1 : '0;
      total++;
      if (clken !== exp) begin bad++; $display("FAIL reset_period cyc=%0d got=%b want=%b", cyc, clken, exp); end
      if (cyc == LOCK || cyc == LOCK + 1) begin
        total++;
        if (locked !== (cyc == LOCK + 1)) begin
          bad++; $display("FAIL first_lock cyc=%0d got=%b want=%b", cyc, locked, cyc == LOCK + 1);
        end
      end
    end
  endtask

  task automatic test_reconfig();
    do_reset();
    while (cyc < 18) tick();
    cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_inc = 8'd128;
    tick();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reconf_ready_low got=%b want=0", cfg_ready); end
    tick();
    total++; if (clken[1] !== 1'b1) begin bad++; $display("FAIL reconf_apply_pulse got=%b want=1", clken[1]); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reconf_ready_back got=%b want=1", cfg_ready); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reconf_lock_drop got=%b want=0", locked); end
    for (int k = 21; k <= 37; k++) begin
      tick();
      total++;
      if (clken[1] !== (cyc % 2 == 0)) begin
        bad++; $display("FAIL reconf_ch1 cyc=%0d got=%b want=%b", cyc, clken[1], cyc % 2 == 0);
      end
      total++;
      if (clken[0] !== (cyc % 4 == 0)) begin
        bad++; $display("FAIL reconf_ch0 cyc=%0d got=%b want=%b", cyc, clken[0], cyc % 4 == 0);
      end
      total++;
      if (locked !== (cyc >= 20 + LOCK + 1)) begin
        bad++; $display("FAIL reconf_relock cyc=%0d got=%b want=%b", cyc, locked, cyc >= 20 + LOCK + 1);
      end
    end
  endtask

  task automatic test_stop_start();
    do_reset();
    while (cyc < 18) tick();
    cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_inc = 8'd0;
    tick();
    cfg_valid = 1'b0;
    tick();
    total++; if (clken[2] !== 1'b1) begin bad++; $display("FAIL stop_last_pulse got=%b want=1", clken[2]); end
    while (cyc < 30) begin
      tick();
      total++;
      if (clken[2] !== 1'b0) begin bad++; $display("FAIL stop_quiet cyc=%0d got=%b want=0", cyc, clken[2]); end
    end
    cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_inc = 8'd32;
    tick();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL start_ready_low got=%b want=0", cfg_ready); end
    tick();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL start_apply_next got=%b want=1", cfg_ready); end
    while (cyc < 48) begin
      tick();
      total++;
      if (clken[2] !== ((cyc - 32) % 8 == 0)) begin
        bad++; $display("FAIL start_period8 cyc=%0d got=%b want=%b", cyc, clken[2], (cyc - 32) % 8 == 0);
      end
    end
  endtask

  task automatic test_bad_chan();
    logic [NCH-1:0] exp;
    do_reset();
    cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_inc = 8'd0;
    tick();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad5_err got=%b want=1", cfg_err); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL bad5_ready got=%b want=1", cfg_ready); end
    cfg_chan = 3'd4;
    tick();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad4_err got=%b want=1", cfg_err); end
    cfg_valid = 1'b0;
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b want=0", cfg_err); end
    while (cyc < 12) begin
      tick();
      exp = (cyc % 4 == 0) ? '1 : '0;
      total++;
      if (clken !== exp) begin bad++; $display("FAIL bad_inc_kept cyc=%0d got=%b want=%b", cyc, clken, exp); end
    end
  endtask

  task automatic test_max_rate();
    int cnt;
    do_reset();
    cfg_valid = 1'b1; cfg_chan = 3'd3; cfg_inc = 8'd255;
    tick();
    cfg_valid = 1'b0;
    while (cyc < 4) tick();
    total++; if (clken[3] !== 1'b1) begin bad++; $display("FAIL max_apply got=%b want=1", clken[3]); end
    cnt = 0;
    repeat (M) begin
      tick();
      if (clken[3]) cnt++;
    end
    total++; if (cnt !== M - 1) begin bad++; $display("FAIL max_rate_count got=%0d want=%0d", cnt, M - 1); end
  endtask

  task automatic test_rate32();
    localparam int N = 50000;
    int cnt, last, min_gap, exp;
    do_reset();
    cnt = 0; last = -1; min_gap = N;
    for (int k = 0; k < N; k++) begin
      tick();
      if (cyc == LOCK32 || cyc == LOCK32 + 1) begin
        total++;
        if (locked32 !== (cyc == LOCK32 + 1)) begin
          bad++; $display("FAIL lock32 cyc=%0d got=%b want=%b", cyc, locked32, cyc == LOCK32 + 1);
        end
      end
      if (clken32[0]) begin
        if (last >= 0 && cyc - last < min_gap) min_gap = cyc - last;
        last = cyc;
        cnt++;
      end
    end
    exp = int'((longint'(N) * INC32) >> 32);
    total++; if (cnt !== exp) begin bad++; $display("FAIL rate32_count got=%0d want=%0d", cnt, exp); end
    total++; if (min_gap < 5) begin bad++; $display("FAIL rate32_gap got=%0d want>=5", min_gap); end
  endtask

  task automatic test_random();
    bit took;
    int r;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (!cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_valid = 1'b1;
        cfg_chan = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, NCH - 1));
        r = int'($urandom_range(0, 5));
        cfg_inc = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 255));
      end
      rst = ($urandom_range(0, 499) == 0);
      took = cfg_valid && !m_pend && !rst;
      tick();
      if (took) cfg_valid = 1'b0;
      total++; if (clken !== m_clken) begin bad++; $display("FAIL rnd_clken n=%0d got=%b want=%b", n, clken, m_clken); end
      total++; if (cfg_ready !== !m_pend) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, cfg_ready, !m_pend); end
      total++; if (cfg_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, cfg_err, m_err); end
      total++; if (locked !== m_locked) begin bad++; $display("FAIL rnd_locked n=%0d got=%b want=%b", n, locked, m_locked); end
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
  endtask

`ifdef CLKEN_SYNTH_TOGGLE_EN
  task automatic test_toggle();
    logic [NCH-1:0] exp;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp = (((cyc - 1) / 4) % 2 == 1) ? '1 : '0;
      total++;
      if (outclk !== exp) begin bad++; $display("FAIL toggle cyc=%0d got=%b want=%b", cyc, outclk, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reconfig();
    test_stop_start();
    test_bad_chan();
    test_max_rate();
    test_rate32();
    test_random();
`ifdef CLKEN_SYNTH_TOGGLE_EN
    test_toggle();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
